// File: rtl/mdu_pkg.sv
// Shared MDU encodings, FSM state constants and default latencies for the core and the decoder.
package mdu_pkg;
  localparam logic [3:0] MDU_OP_NONE  = 4'd0;
  localparam logic [3:0] MDU_OP_MULT  = 4'd1;
  localparam logic [3:0] MDU_OP_MULTU = 4'd2;
  localparam logic [3:0] MDU_OP_DIV   = 4'd3;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [3:0] MDU_OP_MFHI  = 4'd5;
  localparam logic [3:0] MDU_OP_MFLO  = 4'd6;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd7;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;
  localparam int MDU_CNT_W           = 16;

  function automatic logic is_arith_op(input logic [3:0] op);
    return (op >= MDU_OP_MULT) && (op <= MDU_OP_DIVU);
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product and 32-bit quotient/remainder for mult/multu/div/divu.
// Signed division works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        mag_a, mag_b, dvsr_u, q_mag, r_mag, q_u, r_u;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'b0, a} * {32'b0, b};
    div0   = (b == 32'b0);
    mag_a  = a[31] ? (32'b0 - a) : a;
    mag_b  = b[31] ? (32'b0 - b) : b;
    // Substitute a divisor of 1 for zero so the dividers never see x; div0 overrides the result.
    dvsr_u = div0 ? 32'd1 : b;
    q_mag  = mag_a / (div0 ? 32'd1 : mag_b);
    r_mag  = mag_a % (div0 ? 32'd1 : mag_b);
    q_u    = a / dvsr_u;
    r_u    = a % dvsr_u;

    hi_res = 32'b0;
    lo_res = 32'b0;
    case (op)
      MDU_OP_MULT:  {hi_res, lo_res} = prod_s;
      MDU_OP_MULTU: {hi_res, lo_res} = prod_u;
      MDU_OP_DIV: begin
        lo_res = (a[31] ^ b[31]) ? (32'b0 - q_mag) : q_mag;
        hi_res = a[31] ? (32'b0 - r_mag) : r_mag;
      end
      MDU_OP_DIVU: begin
        lo_res = q_u;
        hi_res = r_u;
      end
      default: ;
    endcase
    if (div0 && (op == MDU_OP_DIV || op == MDU_OP_DIVU)) begin
      lo_res = 32'hFFFF_FFFF;
      hi_res = a;
    end
  end
endmodule

// File: rtl/mdu_core.sv
// E-stage multiply/divide unit: HI/LO, fixed-latency IDLE/RUN sequencer, mfhi/mflo read port.
// Define MDU_DIV0_HOLD_EN to leave HI/LO untouched when a divide by zero commits.
module mdu_core
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);
`ifdef MDU_DIV0_HOLD_EN
  localparam logic DIV0_HOLD = 1'b1;
`else
  localparam logic DIV0_HOLD = 1'b0;
`endif
  localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE  = MDU_CNT_W'(1);

  logic [0:0]           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          hi_q, hi_d, lo_q, lo_d, hi_nx_q, hi_nx_d, lo_nx_q, lo_nx_d;
  logic                 hold_q, hold_d;
  logic [31:0]          arith_hi, arith_lo;
  logic                 arith_div0, is_mul, is_div;

  mdu_arith u_arith (
    .op     (mdu_op),
    .a      (a),
    .b      (b),
    .hi_res (arith_hi),
    .lo_res (arith_lo),
    .div0   (arith_div0)
  );

  always_comb begin
    is_mul  = (mdu_op == MDU_OP_MULT) || (mdu_op == MDU_OP_MULTU);
    is_div  = (mdu_op == MDU_OP_DIV) || (mdu_op == MDU_OP_DIVU);
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_nx_d = hi_nx_q;
    lo_nx_d = lo_nx_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush && is_arith_op(mdu_op)) begin
          hi_nx_d = arith_hi;
          lo_nx_d = arith_lo;
          hold_d  = DIV0_HOLD && is_div && arith_div0;
          cnt_d   = is_mul ? MULT_CNT : DIV_CNT;
          state_d = ST_RUN;
        end else if (!flush && mdu_op == MDU_OP_MTHI) begin
          hi_d = a;
        end else if (!flush && mdu_op == MDU_OP_MTLO) begin
          lo_d = a;
        end
      end
      default: begin
        // Commands arriving while running are dropped; flush cannot cancel the in-flight op.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          if (!hold_q) begin
            hi_d = hi_nx_q;
            lo_d = lo_nx_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_nx_q <= '0;
      lo_nx_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_nx_q <= hi_nx_d;
      lo_nx_q <= lo_nx_d;
      hold_q  <= hold_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mdu_out = (mdu_op == MDU_OP_MFHI) ? hi_q :
                   (mdu_op == MDU_OP_MFLO) ? lo_q : 32'b0;
endmodule
